// File: rtl/uart_report_sched_pkg.sv
// Shared types and constants for the UART report scheduler.
// Holds the FSM encoding, ASCII framing bytes and frame lengths.
package uart_report_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_LOAD,
    ST_WAIT
  } state_t;

  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_PLUS  = 8'h2B;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_DOT   = 8'h2E;
  localparam logic [7:0] ASC_R     = 8'h52;
  localparam logic [7:0] ASC_EQ    = 8'h3D;
  localparam logic [7:0] ASC_0     = 8'h30;

  localparam int RPT_LEN = 11;
  localparam int ACK_LEN = 6;

  function automatic logic [7:0] asc_digit(
    input logic [3:0] d
  );
    return ASC_0 + {4'h0, d};
  endfunction

  // Resolution code to bit count, as two BCD nibbles.
  function automatic logic [7:0] ratio_bits(
    input logic [1:0] code
  );
    logic [7:0] r;
    case (code)
      2'd0:    r = 8'h12;
      2'd1:    r = 8'h11;
      2'd2:    r = 8'h10;
      default: r = 8'h09;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_report_sched_if.sv
// Byte-level handshake between the scheduler and the UART
// transmitter.
interface uart_report_sched_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_idle;
  logic       tx_done;

  modport master (
    output tx_start,
    output tx_data,
    input  tx_idle,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx_idle,
    output tx_done
  );
endinterface

// File: rtl/uart_report_sched_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter.
// One bit per cycle, DATA_W cycles after start, then a done pulse.
module uart_report_sched_bin2bcd
  import uart_report_pkg::*;
#(
  parameter int DATA_W = 25,
  parameter int DIGITS = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]   sh;
  logic [CW-1:0]       cnt;
  logic                run;
  logic [4*DIGITS-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (rst) begin
      sh  <= '0;
      cnt <= '0;
      run <= 1'b0;
      bcd <= '0;
    end else if (start) begin
      sh  <= bin;
      bcd <= '0;
      cnt <= CW'(DATA_W);
      run <= 1'b1;
    end else if (run) begin
      bcd <= {adj[4*DIGITS-2:0], sh[DATA_W-1]};
      sh  <= sh << 1;
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        run  <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_report_sched.sv
// Arbitrates the shared UART between periodic temperature reports
// and resolution-change acknowledges; frames and sends the bytes.
module uart_report_sched
  import uart_report_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int REPORT_MS = 1000,
  parameter int DATA_W    = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              report_en,
  input  logic              sign,
  input  logic [DATA_W-1:0] temp_data,
  input  logic [1:0]        ratio_num,
  input  logic              ratio_en,
  output logic              busy,
  uart_report_sched_if.master tx
);

  localparam int TICK  = CLK_FREQ / 1000 * REPORT_MS;
  localparam int CNT_W = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [CNT_W-1:0]  LAST = CNT_W'(TICK - 1);
  localparam logic [DATA_W-1:0] SAT  = DATA_W'(9_999_999);

  state_t           state;
  logic [CNT_W-1:0] per_cnt;
  logic             tick;
  logic             rpt_pend;
  logic             ack_pend;
  logic [1:0]       ratio_q;
  logic [1:0]       ack_code;
  logic             is_rpt;
  logic             neg;
  logic [3:0]       idx;
  logic [3:0]       last;
  logic             grant_ack;
  logic             grant_rpt;
  logic [DATA_W-1:0] conv_in;
  logic             conv_done;
  logic [27:0]      bcd;
  logic [7:0]       rb;
  logic [7:0]       fbyte;

  assign tick      = report_en && (per_cnt == LAST);
  assign grant_ack = (state == ST_IDLE) && ack_pend;
  assign grant_rpt = (state == ST_IDLE) && !ack_pend && rpt_pend;
  assign conv_in   = (temp_data > SAT) ? SAT : temp_data;
  assign last      = is_rpt ? 4'(RPT_LEN - 1) : 4'(ACK_LEN - 1);
  assign rb        = ratio_bits(ack_code);

  uart_report_sched_bin2bcd #(
    .DATA_W (DATA_W),
    .DIGITS (7)
  ) u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (grant_rpt),
    .bin   (conv_in),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // A new event wins over a same-cycle grant clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt  <= '0;
      rpt_pend <= 1'b0;
      ack_pend <= 1'b0;
      ratio_q  <= '0;
    end else begin
      if (!report_en)
        per_cnt <= '0;
      else if (tick)
        per_cnt <= '0;
      else
        per_cnt <= per_cnt + 1'b1;
      rpt_pend <= report_en &&
                  (tick || (rpt_pend && !grant_rpt));
      ack_pend <= ratio_en || (ack_pend && !grant_ack);
      if (ratio_en)
        ratio_q <= ratio_num;
    end
  end

  always_comb begin
    fbyte = ASC_LF;
    if (is_rpt) begin
      case (idx)
        4'd0:    fbyte = neg ? ASC_MINUS : ASC_PLUS;
        4'd1:    fbyte = asc_digit(bcd[27:24]);
        4'd2:    fbyte = asc_digit(bcd[23:20]);
        4'd3:    fbyte = asc_digit(bcd[19:16]);
        4'd4:    fbyte = ASC_DOT;
        4'd5:    fbyte = asc_digit(bcd[15:12]);
        4'd6:    fbyte = asc_digit(bcd[11:8]);
        4'd7:    fbyte = asc_digit(bcd[7:4]);
        4'd8:    fbyte = asc_digit(bcd[3:0]);
        4'd9:    fbyte = ASC_CR;
        default: fbyte = ASC_LF;
      endcase
    end else begin
      case (idx)
        4'd0:    fbyte = ASC_R;
        4'd1:    fbyte = ASC_EQ;
        4'd2:    fbyte = asc_digit(rb[7:4]);
        4'd3:    fbyte = asc_digit(rb[3:0]);
        4'd4:    fbyte = ASC_CR;
        default: fbyte = ASC_LF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      tx.tx_start <= 1'b0;
      tx.tx_data  <= 8'h00;
      busy        <= 1'b0;
      idx         <= '0;
      is_rpt      <= 1'b0;
      neg         <= 1'b0;
      ack_code    <= '0;
    end else begin
      tx.tx_start <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          idx <= '0;
          if (ack_pend) begin
            state    <= ST_LOAD;
            is_rpt   <= 1'b0;
            ack_code <= ratio_q;
            busy     <= 1'b1;
          end else if (rpt_pend) begin
            state  <= ST_CONV;
            is_rpt <= 1'b1;
            neg    <= sign;
            busy   <= 1'b1;
          end
        end
        ST_CONV: begin
          if (conv_done)
            state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (tx.tx_idle) begin
            tx.tx_data  <= fbyte;
            tx.tx_start <= 1'b1;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (tx.tx_done) begin
            if (idx == last) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_LOAD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_report_sched.sv
// Directed bench for uart_report_sched with a simple UART model
// that captures every launched byte.
module tb_uart_report_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        report_en = 1'b0;
  logic        sign = 1'b0;
  logic [24:0] temp_data = '0;
  logic [1:0]  ratio_num = '0;
  logic        ratio_en = 1'b0;
  logic        busy;

  uart_report_sched_if ui();

  int   checks = 0;
  int   errors = 0;
  int   wide_cnt = 0;
  int   bcnt = 0;
  logic hold_idle = 1'b0;
  logic prev_start = 1'b0;
  logic [7:0] rxq[$];

  always #5 clk = ~clk;

  uart_report_sched #(
    .CLK_FREQ  (400_000),
    .REPORT_MS (1),
    .DATA_W    (25)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .report_en (report_en),
    .sign      (sign),
    .temp_data (temp_data),
    .ratio_num (ratio_num),
    .ratio_en  (ratio_en),
    .busy      (busy),
    .tx        (ui)
  );

  // UART model: 6 negedges per byte, then tx_done with tx_idle.
  initial begin
    ui.tx_idle = 1'b1;
    ui.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      ui.tx_done = 1'b0;
      if (rst) begin
        bcnt = 0;
      end else if (ui.tx_start) begin
        if (prev_start || bcnt != 0) wide_cnt++;
        rxq.push_back(ui.tx_data);
        bcnt = 6;
      end else if (bcnt > 0) begin
        bcnt--;
        ui.tx_done = (bcnt == 0);
      end
      prev_start = ui.tx_start;
      ui.tx_idle = (bcnt == 0) && !hold_idle;
    end
  end

  function automatic string got_str();
    string r = "";
    foreach (rxq[i]) r = $sformatf("%s%c", r, rxq[i]);
    return r;
  endfunction

  function automatic string show(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0D) r = {r, "<CR>"};
      else if (s[i] == 8'h0A) r = {r, "<LF>"};
      else r = $sformatf("%s%c", r, s[i]);
    end
    return r;
  endfunction

  task automatic wait_busy(input string tag);
    int t = 0;
    while (busy !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy_timeout busy=%b need 1", tag, busy);
    end
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int t = 0;
    while (rxq.size() < n && t < 2000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (rxq.size() < n) begin
      errors++;
      $display("FAIL %s_byte_timeout got %0d need %0d",
               tag, rxq.size(), n);
    end
  endtask

  task automatic wait_done(input int n, input string tag);
    int t = 0;
    while (!(rxq.size() >= n && busy === 1'b0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 3000) begin
      errors++;
      $display("FAIL %s_done_timeout bytes %0d need %0d",
               tag, rxq.size(), n);
    end
  endtask

  task automatic pulse_ratio(input logic [1:0] code);
    ratio_num = code;
    ratio_en  = 1'b1;
    @(negedge clk);
    ratio_en  = 1'b0;
  endtask

  task automatic run_report(
    input logic        sg,
    input logic [24:0] val,
    input string       exp,
    input string       tag
  );
    rxq.delete();
    sign      = sg;
    temp_data = val;
    report_en = 1'b1;
    wait_busy(tag);
    report_en = 1'b0;
    wait_done(exp.len(), tag);
    checks++;
    if (got_str() != exp) begin
      errors++;
      $display("FAIL %s got %s need %s",
               tag, show(got_str()), show(exp));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 3;
    if (ui.tx_start !== 1'b0) begin
      errors++;
      $display("FAIL rst_tx_start got %b need 0", ui.tx_start);
    end
    if (ui.tx_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_tx_data got %h need 00", ui.tx_data);
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got %b need 0", busy);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rxq.size() != 0) begin
      errors++;
      $display("FAIL idle_after_rst busy %b bytes %0d need 0 0",
               busy, rxq.size());
    end
  endtask

  task automatic test_report_basic();
    int t = 0;
    string exp = "+025.3125\r\n";
    rxq.delete();
    sign      = 1'b0;
    temp_data = 25'd253125;
    report_en = 1'b1;
    while (busy !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t !== 401) begin
      errors++;
      $display("FAIL period got %0d need 401", t);
    end
    report_en = 1'b0;
    t = 0;
    while (ui.tx_start !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t !== 27) begin
      errors++;
      $display("FAIL rpt_latency got %0d need 27", t);
    end
    wait_done(11, "basic");
    checks++;
    if (got_str() != exp) begin
      errors++;
      $display("FAIL basic got %s need %s",
               show(got_str()), show(exp));
    end
  endtask

  task automatic test_patterns();
    run_report(1'b1, 25'd100625, "-010.0625\r\n", "neg");
    run_report(1'b0, 25'h1FFFFFF, "+999.9999\r\n", "sat_max");
    run_report(1'b0, 25'd10_000_000, "+999.9999\r\n", "sat_edge");
    run_report(1'b0, 25'd9_999_999, "+999.9999\r\n", "max_exact");
    run_report(1'b0, 25'd0, "+000.0000\r\n", "zero");
  endtask

  task automatic test_ack();
    int t = 0;
    string exp = "R=11\r\n";
    rxq.delete();
    pulse_ratio(2'd1);
    wait_busy("ack");
    while (ui.tx_start !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t !== 1) begin
      errors++;
      $display("FAIL ack_latency got %0d need 1", t);
    end
    wait_done(6, "ack");
    checks++;
    if (got_str() != exp) begin
      errors++;
      $display("FAIL ack got %s need %s",
               show(got_str()), show(exp));
    end
  endtask

  task automatic test_ack_mid_report();
    string exp = "+025.3125\r\nR=09\r\n";
    rxq.delete();
    sign      = 1'b0;
    temp_data = 25'd253125;
    report_en = 1'b1;
    wait_busy("mid");
    report_en = 1'b0;
    wait_bytes(3, "mid");
    pulse_ratio(2'd3);
    wait_done(17, "mid");
    checks++;
    if (got_str() != exp) begin
      errors++;
      $display("FAIL ack_mid got %s need %s",
               show(got_str()), show(exp));
    end
  endtask

  task automatic test_same_cycle();
    string exp = "R=12\r\n-010.0625\r\n";
    rxq.delete();
    sign      = 1'b1;
    temp_data = 25'd100625;
    ratio_num = 2'd0;
    report_en = 1'b1;
    repeat (399) @(negedge clk);
    pulse_ratio(2'd0);
    wait_done(17, "same");
    report_en = 1'b0;
    checks++;
    if (got_str() != exp) begin
      errors++;
      $display("FAIL same_cycle got %s need %s",
               show(got_str()), show(exp));
    end
  endtask

  task automatic test_merge();
    string exp = "+999.9999\r\nR=10\r\n";
    rxq.delete();
    sign      = 1'b0;
    temp_data = 25'h1FFFFFF;
    report_en = 1'b1;
    wait_busy("merge");
    report_en = 1'b0;
    wait_bytes(2, "merge");
    pulse_ratio(2'd1);
    wait_bytes(5, "merge");
    pulse_ratio(2'd2);
    wait_done(17, "merge");
    repeat (20) @(negedge clk);
    checks++;
    if (got_str() != exp) begin
      errors++;
      $display("FAIL merge got %s need %s",
               show(got_str()), show(exp));
    end
  endtask

  task automatic test_hold_idle();
    string exp = "R=12\r\n";
    rxq.delete();
    hold_idle = 1'b1;
    repeat (2) @(negedge clk);
    pulse_ratio(2'd0);
    repeat (500) @(negedge clk);
    checks += 2;
    if (rxq.size() != 0) begin
      errors++;
      $display("FAIL hold_no_start got %0d bytes need 0",
               rxq.size());
    end
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_busy got %b need 1", busy);
    end
    hold_idle = 1'b0;
    wait_done(6, "hold");
    checks++;
    if (got_str() != exp) begin
      errors++;
      $display("FAIL hold got %s need %s",
               show(got_str()), show(exp));
    end
  endtask

  task automatic test_rst_mid();
    rxq.delete();
    sign      = 1'b0;
    temp_data = 25'd253125;
    report_en = 1'b1;
    wait_busy("rstmid");
    report_en = 1'b0;
    wait_bytes(5, "rstmid");
    rst = 1'b1;
    @(negedge clk);
    checks += 2;
    if (ui.tx_start !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_tx_start got %b need 0", ui.tx_start);
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_busy got %b need 0", busy);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_no_resume busy %b need 0", busy);
    end
    run_report(1'b0, 25'd7, "+000.0007\r\n", "post_rst");
  endtask

  task automatic test_pulse_width();
    checks++;
    if (wide_cnt !== 0) begin
      errors++;
      $display("FAIL start_pulse_width bad %0d need 0", wide_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_report_basic();
    test_patterns();
    test_ack();
    test_ack_mid_report();
    test_same_cycle();
    test_merge();
    test_hold_idle();
    test_rst_mid();
    test_pulse_width();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
